vud_step_sched: RTL



---
 rtl/vud_step_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vud_step_sched.sv
// Round-robin step scheduler for the value up/down datapath: grants one of two
// requesters and auto-repeats its steps while held. Magnitude escalation on long
// holds is built only when VUD_SCHED_ACCEL_EN is defined.
module vud_step_sched #(
    parameter int REPEAT_DLY = 15
`ifdef VUD_SCHED_ACCEL_EN
    ,parameter int ACCEL_STEPS = 4
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_req_i,
    input  logic       a_dir_i,
    input  logic [1:0] a_mag_i,
    output logic       a_gnt_o,
    input  logic       b_req_i,
    input  logic       b_dir_i,
    input  logic [1:0] b_mag_i,
    output logic       b_gnt_o,
    input  logic       freeze_i,
    output logic       step_o,
    output logic       step_dir_o,
    output logic [1:0] step_mag_o,
    output logic       lock_n_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_e;

    localparam logic [7:0] HOLD_LOAD = 8'(REPEAT_DLY - 1);

    state_e     state_q, state_d;
    logic       ownerB_q, ownerB_d;
    logic       lastOwnerB_q, lastOwnerB_d;
    logic       dir_q, dir_d;
    logic [1:0] mag_q, mag_d;
    logic [7:0] cnt_q, cnt_d;

    logic       stepStb_q;
    logic       stepDir_q;
    logic [1:0] stepMag_q;
    logic       aGnt_q;
    logic       bGnt_q;
    logic       busy_q;
    logic       lockN_q;

    logic       ownReq;
    logic       othReq;
    logic       pickB;
    logic       issueNext;
    logic [1:0] issueMag;

    assign ownReq    = ownerB_q ? b_req_i : a_req_i;
    assign othReq    = ownerB_q ? a_req_i : b_req_i;
    // On a tie the requester that did not own the datapath last time wins.
    assign pickB     = b_req_i & (~a_req_i | ~lastOwnerB_q);
    assign issueNext = (state_d == ISSUE);

    always_comb begin
        state_d      = state_q;
        ownerB_d     = ownerB_q;
        lastOwnerB_d = lastOwnerB_q;
        dir_d        = dir_q;
        mag_d        = mag_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (!freeze_i && (a_req_i || b_req_i)) begin
                    ownerB_d = pickB;
                    dir_d    = pickB ? b_dir_i : a_dir_i;
                    mag_d    = pickB ? b_mag_i : a_mag_i;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = HOLD_LOAD;
                state_d = HOLD;
            end
            HOLD: begin
                if (!ownReq) begin
                    lastOwnerB_d = ownerB_q;
                    state_d      = IDLE;
                end else if (freeze_i) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (othReq) begin
                    lastOwnerB_d = ownerB_q;
                    state_d      = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef VUD_SCHED_ACCEL_EN
    localparam logic [7:0] ACCEL_DIV = 8'(ACCEL_STEPS);

    logic [7:0] repCnt_q, repCnt_d;
    logic [7:0] accelLvl;
    logic [8:0] magSum;

    // repCnt_d counts steps already issued in this grant, so it indexes the step about to go out.
    always_comb begin
        repCnt_d = repCnt_q;
        if (state_q == IDLE && state_d == ISSUE) begin
            repCnt_d = 8'd0;
        end else if (state_q == ISSUE && repCnt_q != 8'hFF) begin
            repCnt_d = repCnt_q + 8'd1;
        end
    end

    assign accelLvl = repCnt_d / ACCEL_DIV;
    assign magSum   = {7'd0, mag_d} + {1'b0, accelLvl};
    assign issueMag = (magSum > 9'd3) ? 2'd3 : magSum[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            repCnt_q <= 8'd0;
        end else begin
            repCnt_q <= repCnt_d;
        end
    end
`else
    assign issueMag = mag_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ownerB_q     <= 1'b0;
            lastOwnerB_q <= 1'b1;
            dir_q        <= 1'b0;
            mag_q        <= 2'd0;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            ownerB_q     <= ownerB_d;
            lastOwnerB_q <= lastOwnerB_d;
            dir_q        <= dir_d;
            mag_q        <= mag_d;
            cnt_q        <= cnt_d;
        end
    end

    // Outputs are registered from next-state so a step appears in the same cycle as ISSUE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stepStb_q <= 1'b0;
            stepDir_q <= 1'b0;
            stepMag_q <= 2'd0;
            aGnt_q    <= 1'b0;
            bGnt_q    <= 1'b0;
            busy_q    <= 1'b0;
            lockN_q   <= 1'b0;
        end else begin
            stepStb_q <= issueNext;
            stepDir_q <= issueNext ? dir_d : 1'b0;
            stepMag_q <= issueNext ? issueMag : 2'd0;
            aGnt_q    <= (state_d != IDLE) && !ownerB_d;
            bGnt_q    <= (state_d != IDLE) && ownerB_d;
            busy_q    <= (state_d != IDLE);
            lockN_q   <= ~freeze_i;
        end
    end

    assign step_o     = stepStb_q;
    assign step_dir_o = stepDir_q;
    assign step_mag_o = stepMag_q;
    assign a_gnt_o    = aGnt_q;
    assign b_gnt_o    = bGnt_q;
    assign busy_o     = busy_q;
    assign lock_n_o   = lockN_q;

endmodule
